// File: rtl/decode_pkg.sv
// Shared types for the decode queue: instruction classes, RV32I opcodes and the
// decoded-instruction record produced by rv32i_decoder.
package decode_pkg;

    typedef enum logic [3:0] {
        CLASS_ILLEGAL = 4'd0,
        CLASS_ALU_R   = 4'd1,
        CLASS_ALU_I   = 4'd2,
        CLASS_LOAD    = 4'd3,
        CLASS_STORE   = 4'd4,
        CLASS_BRANCH  = 4'd5,
        CLASS_JAL     = 4'd6,
        CLASS_JALR    = 4'd7,
        CLASS_LUI     = 4'd8,
        CLASS_AUIPC   = 4'd9,
        CLASS_SYSTEM  = 4'd10
    } instr_class_e;

    localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
    localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        instr_class_e iclass;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
        logic [31:0]  imm;
        logic         illegal;
    } decoded_instr_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and dispatch-side signals of the decode queue.
// With DECODE_QUEUE_STATS_EN defined the statistics counters are carried as well.
interface decode_queue_if #(
    parameter int DEPTH          = 4,
    parameter int ROM_ADDR_WIDTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]               fetch_instruction;
    logic                      fetch_valid;
    logic                      stall;
    logic                      flush;
    logic [ROM_ADDR_WIDTH-1:0] flush_pc;
    logic                      dec_valid;
    logic                      dec_ready;
    logic [ROM_ADDR_WIDTH-1:0] dec_pc;
    logic [31:0]               dec_instruction;
    logic [3:0]                dec_class;
    logic [4:0]                dec_rd;
    logic [4:0]                dec_rs1;
    logic [4:0]                dec_rs2;
    logic [2:0]                dec_funct3;
    logic [6:0]                dec_funct7;
    logic [31:0]               dec_imm;
    logic                      dec_illegal;
    logic [CNT_W-1:0]          q_count;
`ifdef DECODE_QUEUE_STATS_EN
    logic [31:0]               stat_stall_cycles;
    logic [15:0]               stat_illegal;

    modport master (
        output fetch_instruction, fetch_valid, flush, flush_pc, dec_ready,
        input  stall, dec_valid, dec_pc, dec_instruction, dec_class, dec_rd, dec_rs1,
               dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal, q_count,
               stat_stall_cycles, stat_illegal
    );
    modport slave (
        input  fetch_instruction, fetch_valid, flush, flush_pc, dec_ready,
        output stall, dec_valid, dec_pc, dec_instruction, dec_class, dec_rd, dec_rs1,
               dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal, q_count,
               stat_stall_cycles, stat_illegal
    );
`else
    modport master (
        output fetch_instruction, fetch_valid, flush, flush_pc, dec_ready,
        input  stall, dec_valid, dec_pc, dec_instruction, dec_class, dec_rd, dec_rs1,
               dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal, q_count
    );
    modport slave (
        input  fetch_instruction, fetch_valid, flush, flush_pc, dec_ready,
        output stall, dec_valid, dec_pc, dec_instruction, dec_class, dec_rd, dec_rs1,
               dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal, q_count
    );
`endif
endinterface

// File: rtl/rv32i_decoder.sv
// Combinational RV32I base decoder: raw instruction word to class, register fields
// and sign-extended immediate. Unknown opcodes (including 32'h0) decode as ILLEGAL.
module rv32i_decoder
    import decode_pkg::*;
(
    input  logic [31:0]    instruction,
    output decoded_instr_t decoded
);

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        decoded         = '0;
        decoded.rd      = instruction[11:7];
        decoded.rs1     = instruction[19:15];
        decoded.rs2     = instruction[24:20];
        decoded.funct3  = instruction[14:12];
        decoded.funct7  = instruction[31:25];
        decoded.iclass  = CLASS_ILLEGAL;
        decoded.illegal = 1'b0;
        case (instruction[6:0])
            OPC_ALU_R:  decoded.iclass = CLASS_ALU_R;
            OPC_ALU_I:  begin decoded.iclass = CLASS_ALU_I;  decoded.imm = imm_i; end
            OPC_LOAD:   begin decoded.iclass = CLASS_LOAD;   decoded.imm = imm_i; end
            OPC_STORE:  begin decoded.iclass = CLASS_STORE;  decoded.imm = imm_s; end
            OPC_BRANCH: begin decoded.iclass = CLASS_BRANCH; decoded.imm = imm_b; end
            OPC_JAL:    begin decoded.iclass = CLASS_JAL;    decoded.imm = imm_j; end
            OPC_JALR:   begin decoded.iclass = CLASS_JALR;   decoded.imm = imm_i; end
            OPC_LUI:    begin decoded.iclass = CLASS_LUI;    decoded.imm = imm_u; end
            OPC_AUIPC:  begin decoded.iclass = CLASS_AUIPC;  decoded.imm = imm_u; end
            OPC_SYSTEM: begin decoded.iclass = CLASS_SYSTEM; decoded.imm = imm_i; end
            default:    decoded.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// PC-tagging instruction FIFO between fetch and rename/dispatch, decoding its head entry.
// Define DECODE_QUEUE_STATS_EN to add saturating stall-cycle and popped-illegal counters.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int ROM_ADDR_WIDTH = 4
) (
    input logic           clock,
    input logic           reset,
    decode_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]               instr;
        logic [ROM_ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                    mem_q [DEPTH];
    entry_t                    mem_d [DEPTH];
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [ROM_ADDR_WIDTH-1:0] tag_pc_q, tag_pc_d;

    entry_t         head;
    decoded_instr_t head_dec;
    logic           not_empty, full, push, pop;

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = bus.fetch_valid && !full && !bus.flush;
    assign pop       = not_empty && bus.dec_ready && !bus.flush;

    rv32i_decoder u_decoder (
        .instruction (head.instr),
        .decoded     (head_dec)
    );

    // Flush overrides any push or pop in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        tag_pc_d = tag_pc_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            tag_pc_d = bus.flush_pc;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: bus.fetch_instruction, pc: tag_pc_q};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                tag_pc_d        = tag_pc_q + ROM_ADDR_WIDTH'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            tag_pc_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            tag_pc_q <= tag_pc_d;
        end
    end

    // Decoded fields read as zero whenever the queue is empty.
    assign bus.stall           = full;
    assign bus.q_count         = count_q;
    assign bus.dec_valid       = not_empty && !bus.flush;
    assign bus.dec_pc          = not_empty ? head.pc : '0;
    assign bus.dec_instruction = not_empty ? head.instr : '0;
    assign bus.dec_class       = not_empty ? head_dec.iclass : 4'd0;
    assign bus.dec_rd          = not_empty ? head_dec.rd : '0;
    assign bus.dec_rs1         = not_empty ? head_dec.rs1 : '0;
    assign bus.dec_rs2         = not_empty ? head_dec.rs2 : '0;
    assign bus.dec_funct3      = not_empty ? head_dec.funct3 : '0;
    assign bus.dec_funct7      = not_empty ? head_dec.funct7 : '0;
    assign bus.dec_imm         = not_empty ? head_dec.imm : '0;
    assign bus.dec_illegal     = not_empty && head_dec.illegal;

`ifdef DECODE_QUEUE_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        illegal_cnt_d  = illegal_cnt_q;
        if (full && bus.fetch_valid && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (pop && head_dec.illegal && (illegal_cnt_q != '1))
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            illegal_cnt_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            illegal_cnt_q  <= illegal_cnt_d;
        end
    end

    assign bus.stat_stall_cycles = stall_cycles_q;
    assign bus.stat_illegal      = illegal_cnt_q;
`endif

endmodule
